// File: rtl/psc_trigger_pkg.sv
// psc_trigger_pkg: shared frame constants, link defaults and receiver FSM states
package psc_trigger_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;
  localparam int FRAME_DATA_BITS = 8;
  localparam int DEF_CLKS_PER_BIT = 10;
  localparam logic [7:0] DEF_TRIGGER_CODE = 8'hA5;
  localparam int DEF_TRIG_WIDTH = 100;
  function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/psc_rx_filter.sv
// psc_rx_filter: 2-FF synchronizer, 3-tap majority vote and falling-edge strobe
module psc_rx_filter
  import psc_trigger_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_out,
  output logic fall
);
  logic s1_q, s1_d, s2_q, s2_d, t0_q, t0_d, t1_q, t1_d;
  logic filt_q, filt_d, fall_q, fall_d, seen_q, seen_d;
  logic [3:0] warm_q, warm_d;
  logic maj;
  // Vote over three synchronized taps; a fall only counts once the line was seen high after reset
  always_comb begin
    s1_d = line_in;
    s2_d = s1_q;
    t0_d = s2_q;
    t1_d = t0_q;
    maj = (s2_q & t0_q) | (s2_q & t1_q) | (t0_q & t1_q);
    filt_d = maj;
    fall_d = seen_q & filt_q & ~maj;
    warm_d = {warm_q[2:0], 1'b1};
    seen_d = seen_q | (warm_q[3] & filt_q);
  end
  // Pipeline resets idle-high; warm/seen stop a line already low at release from posing as a start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      t0_q <= 1'b1;
      t1_q <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      seen_q <= 1'b0;
      warm_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      t0_q <= t0_d;
      t1_q <= t1_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
      seen_q <= seen_d;
      warm_q <= warm_d;
    end
  end
  assign line_out = filt_q;
  assign fall = fall_q;
endmodule

// File: rtl/psc_trigger_rx.sv
// psc_trigger_rx: trigger-link frame receiver with parity/framing checks and trigger regeneration
module psc_trigger_rx
  import psc_trigger_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [7:0] TRIGGER_CODE = DEF_TRIGGER_CODE,
  parameter int TRIG_WIDTH = DEF_TRIG_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psc_input,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       trigger_out,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TRIG_WIDTH + 1);
  localparam int BW = $clog2(FRAME_DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_DATA_BITS - 1);
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [FRAME_DATA_BITS-1:0] sh_q, sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic par_q, par_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic trig_q, trig_d, busy_q, busy_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic filt, fall;
  psc_rx_filter u_filter (
    .clk(clk),
    .reset(reset),
    .line_in(psc_input),
    .line_out(filt),
    .fall(fall)
  );
  // Frame FSM: bit timing, shifting, end-of-frame checks and trigger width counter
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    rx_data_d = rx_data_q;
    valid_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        state_d = fall ? ST_START : ST_IDLE;
      end
      ST_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = filt ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        sh_d = {filt, sh_q[FRAME_DATA_BITS-1:1]};
        bit_d = bit_q + BW'(1);
        state_d = (bit_q == LAST_BIT) ? ST_PARITY : ST_DATA;
      end
      ST_PARITY: if (cnt_q == LAST) begin
        cnt_d = '0;
        par_d = filt;
        state_d = ST_STOP;
      end
      ST_STOP: if (cnt_q == LAST) begin
        cnt_d = '0;
        ferr_d = ~filt;
        valid_d = filt & odd_parity_ok(sh_q, par_q);
        perr_d = filt & ~odd_parity_ok(sh_q, par_q);
        rx_data_d = valid_d ? sh_q : rx_data_q;
        state_d = filt ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        cnt_d = filt ? cnt_q + CW'(1) : '0;
        if (filt && cnt_q == LAST) begin
          cnt_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tcnt_d = (valid_d && sh_q == TRIGGER_CODE) ? TW'(TRIG_WIDTH) :
             (tcnt_q != '0) ? tcnt_q - TW'(1) : '0;
    trig_d = tcnt_d != '0;
    busy_d = state_d != ST_IDLE;
  end
  // State and registered outputs; reset aborts any frame in flight without strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      rx_data_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      tcnt_q <= '0;
      trig_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      rx_data_q <= rx_data_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      tcnt_q <= tcnt_d;
      trig_q <= trig_d;
      busy_q <= busy_d;
    end
  end
  assign rx_data = rx_data_q;
  assign rx_valid = valid_q;
  assign parity_err = perr_q;
  assign framing_err = ferr_q;
  assign trigger_out = trig_q;
  assign busy = busy_q;
endmodule
